// File: rtl/modulo_contador_sync_7_bits_descendente_pkg.sv
// Shared constants and state encoding for the 7-bit down counter.
package modulo_contador_sync_7_bits_descendente_pkg;

  localparam int unsigned LARGURA = 7;
  localparam logic [LARGURA-1:0] VALOR_MAX = 7'd127;
  localparam logic [LARGURA-1:0] VALOR_UM  = 7'd1;

  typedef enum logic {
    PARADO   = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

endpackage

// File: rtl/modulo_contador_sync_7_bits_descendente_celula.sv
// One counter bit: T flip-flop with async clear/preset, per-bit load and borrow stage.
module modulo_celula_descendente (
  input  logic clk,
  input  logic clr,
  input  logic prst,
  input  logic carrega,
  input  logic bit_carga,
  input  logic conta,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  logic t;

  // Load toggles only the bits that differ from the value to load.
  assign t = carrega ? (q ^ bit_carga) : (conta & borrow_in);

  always_ff @(posedge clk or posedge clr or posedge prst) begin
    if (clr) begin
      q <= 1'b0;
    end else if (prst) begin
      q <= 1'b1;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign borrow_out = borrow_in & ~q;

endmodule

// File: rtl/modulo_contador_sync_7_bits_descendente.sv
// 7-bit down counter with load, stop-at-zero / wrap modes and registered end/borrow pulses.
module modulo_contador_sync_7_bits_descendente
  import modulo_contador_sync_7_bits_descendente_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               prst,
  input  logic               habilita,
  input  logic               carrega,
  input  logic [LARGURA-1:0] valor_carga,
  input  logic               modo_parada,
  output logic [LARGURA-1:0] q,
  output logic               zero,
  output logic               fim,
  output logic               emprestimo
);

  estado_t          estado;
  logic [LARGURA:0] borrow;
  logic             conta;

  // The end of the borrow chain is high exactly when every bit is zero.
  assign borrow[0] = 1'b1;
  assign zero      = borrow[LARGURA];

  // Counting at zero in stop mode only parks the FSM, q must not wrap.
  assign conta = (estado == CONTANDO) & habilita & ~(zero & modo_parada);

  for (genvar i = 0; i < LARGURA; i++) begin : g_celula
    modulo_celula_descendente u_celula (
      .clk        (clk),
      .clr        (clr),
      .prst       (prst),
      .carrega    (carrega),
      .bit_carga  (valor_carga[i]),
      .conta      (conta),
      .borrow_in  (borrow[i]),
      .q          (q[i]),
      .borrow_out (borrow[i+1])
    );
  end

  // Control FSM and pulse registers, pulses aligned with the q they describe.
  always_ff @(posedge clk or posedge clr or posedge prst) begin
    if (clr) begin
      estado     <= PARADO;
      fim        <= 1'b0;
      emprestimo <= 1'b0;
    end else if (prst) begin
      estado     <= CONTANDO;
      fim        <= 1'b0;
      emprestimo <= 1'b0;
    end else begin
      fim        <= 1'b0;
      emprestimo <= 1'b0;
      if (carrega) begin
        estado <= ((valor_carga == '0) && modo_parada) ? PARADO : CONTANDO;
      end else if (estado == PARADO) begin
        if (!modo_parada) begin
          estado <= CONTANDO;
        end
      end else if (habilita) begin
        if (zero) begin
          if (modo_parada) begin
            estado <= PARADO;
          end else begin
            emprestimo <= 1'b1;
          end
        end else if ((q == VALOR_UM) && modo_parada) begin
          estado <= PARADO;
          fim    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_modulo_contador_sync_7_bits_descendente.sv
// Directed and randomized checks of the down counter against a behavioural model.
module tb_modulo_contador_sync_7_bits_descendente;

  logic       clk = 1'b0;
  logic       clr, prst, habilita, carrega, modo_parada;
  logic [6:0] valor_carga;
  logic [6:0] q;
  logic       zero, fim, emprestimo;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int mq;
  bit m_parado;
  bit m_fim;
  bit m_emp;

  modulo_contador_sync_7_bits_descendente dut (
    .clk         (clk),
    .clr         (clr),
    .prst        (prst),
    .habilita    (habilita),
    .carrega     (carrega),
    .valor_carga (valor_carga),
    .modo_parada (modo_parada),
    .q           (q),
    .zero        (zero),
    .fim         (fim),
    .emprestimo  (emprestimo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " q"}, int'(q), mq);
    check({tag, " zero"}, int'(zero), (mq == 0) ? 1 : 0);
    check({tag, " fim"}, int'(fim), int'(m_fim));
    check({tag, " emprestimo"}, int'(emprestimo), int'(m_emp));
  endtask

  task automatic model_clear();
    mq = 0; m_parado = 1'b1; m_fim = 1'b0; m_emp = 1'b0;
  endtask

  task automatic model_preset();
    mq = 127; m_parado = 1'b0; m_fim = 1'b0; m_emp = 1'b0;
  endtask

  // Behavioural rules for one rising edge with no async control active.
  task automatic model_edge();
    m_fim = 1'b0;
    m_emp = 1'b0;
    if (carrega) begin
      mq = int'(valor_carga);
      m_parado = (mq == 0) && modo_parada;
    end else if (m_parado) begin
      if (!modo_parada) m_parado = 1'b0;
    end else if (habilita) begin
      if (mq == 0 && modo_parada) begin
        m_parado = 1'b1;
      end else begin
        if (mq == 0) m_emp = 1'b1;
        mq = (mq + 127) % 128;
        if (mq == 0 && modo_parada) begin
          m_fim = 1'b1;
          m_parado = 1'b1;
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (clr) model_clear();
    else if (prst) model_preset();
    else model_edge();
    #1;
    check_all(tag);
  endtask

  // Assert clr/prst between edges, check the immediate effect, then release.
  task automatic pulse_async(input logic c, input logic p, input string tag);
    #2;
    clr = c;
    prst = p;
    #1;
    if (c) model_clear();
    else if (p) model_preset();
    check_all(tag);
    #1;
    clr = 1'b0;
    prst = 1'b0;
  endtask

  task automatic load(input int v);
    carrega = 1'b1;
    valor_carga = 7'(v);
    tick("load");
    carrega = 1'b0;
  endtask

  initial begin
    clr = 1'b1; prst = 1'b0; habilita = 1'b0; carrega = 1'b0;
    valor_carga = '0; modo_parada = 1'b1;
    model_clear();
    #1;
    check_all("reset_async");
    tick("reset_hold");
    tick("reset_hold");
    clr = 1'b0;

    // PARADO after reset ignores habilita
    habilita = 1'b1;
    repeat (5) tick("parado_after_reset");
    pulse_async(1'b1, 1'b0, "clr_mid_cycle");

    // Stop mode: 3 -> 2,1,0 then hold
    modo_parada = 1'b1;
    habilita = 1'b0;
    load(3);
    habilita = 1'b1;
    repeat (7) tick("stop_mode");

    // Wrap mode: 1 -> 0 -> 127 (borrow) -> 126
    modo_parada = 1'b0;
    habilita = 1'b0;
    load(1);
    habilita = 1'b1;
    repeat (3) tick("wrap_mode");

    // Load wins over count
    habilita = 1'b0;
    load(10);
    habilita = 1'b1;
    load(50);
    habilita = 1'b0;
    repeat (3) tick("hold_50");

    // Preset, then preset with clear
    load(20);
    pulse_async(1'b0, 1'b1, "prst_async");
    tick("after_prst");
    pulse_async(1'b1, 1'b1, "prst_and_clr");
    modo_parada = 1'b0;
    load(5);
    habilita = 1'b1;
    repeat (2) tick("count_after_release");

    // Mode change while parked at zero
    modo_parada = 1'b1;
    habilita = 1'b0;
    load(1);
    habilita = 1'b1;
    tick("reach_zero");
    tick("parked");
    modo_parada = 1'b0;
    tick("mode_change_edge");
    tick("mode_change_wrap");
    tick("mode_change_after");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      carrega     = ($urandom_range(0, 7) == 0);
      habilita    = ($urandom_range(0, 3) != 0);
      valor_carga = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 4)) : 7'($urandom);
      if ($urandom_range(0, 9) == 0) modo_parada = ~modo_parada;
      if ($urandom_range(0, 59) == 0) begin
        pulse_async(1'($urandom_range(0, 1)), 1'b1, "rand_async");
      end
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/modulo_contador_sync_7_bits_descendente.md
Name: modulo_contador_sync_7_bits_descendente

Overview:
- 7-bit synchronous down counter (countdown timer): the descending counterpart of the ascending T-flip-flop counter.
- Adds parallel load, stop-at-zero vs wrap mode, and registered end/borrow pulses.
- Used wherever the design must count a loaded value down to zero, e.g. timeouts and reverse displays.
- Built from toggle flip-flops with a borrow chain on inverted outputs.

Parameters:
- LARGURA, 7, counter width. Fixed; the package constant is used, not overridden.
- VALOR_MAX, 127, wrap value (all ones).

Ports:
- clk  input  1  single clock, rising edge.
- clr  input  1  asynchronous reset, active-high; dominant over every other input.
- prst  input  1  asynchronous preset, active-high; q to VALOR_MAX; loses to clr.
- habilita  input  1  count enable (first-stage toggle input).
- carrega  input  1  synchronous parallel load.
- valor_carga  input  7  value loaded when carrega=1.
- modo_parada  input  1  1 = stop at zero; 0 = wrap 0 -> 127.
- q  output  7  count value.
- zero  output  1  combinational, (q == 0).
- fim  output  1  registered one-cycle pulse: count reached zero in stop mode.
- emprestimo  output  1  registered one-cycle pulse: wrap 0 -> 127 occurred.

Behaviour:
- Reset and preset:
  - clr=1 (async): q=0, estado=PARADO, fim=0, emprestimo=0, zero=1. Holds while clr=1.
  - prst=1 with clr=0 (async): q=127, estado=CONTANDO, fim=0, emprestimo=0.
- Synchronous priority at each edge: carrega > habilita.
- FSM states:
  - CONTANDO: decrementing allowed.
  - PARADO: q frozen and habilita ignored.
- carrega=1:
  - q <= valor_carga; fim <= 0; emprestimo <= 0.
  - Next state is PARADO if valor_carga==0 and modo_parada=1 (no fim pulse); otherwise CONTANDO.
- CONTANDO, habilita=1:
  - q>1: q <= q-1.
  - q==1: q <= 0. If modo_parada=1, next state is PARADO and fim=1 during the cycle q first shows 0. If modo_parada=0, stay in CONTANDO.
  - q==0, modo_parada=0: q <= 127, emprestimo=1 for exactly one cycle.
  - q==0, modo_parada=1 (mode changed mid-count): q holds, next state is PARADO, no fim.
- CONTANDO, habilita=0: q holds; fim and emprestimo return to 0.
- PARADO:
  - q holds and pulses are 0.
  - Exits only via carrega, prst, clr, or modo_parada=0. modo_parada=0 moves to CONTANDO with no decrement on that edge.
- Latency and timing:
  - q updates one edge after the inputs are sampled.
  - fim and emprestimo are aligned with the q value that caused them.
  - Pulses never exceed one cycle unless retriggered.
- Arithmetic: modulo 2^7; no intermediate wider than 7 bits.
- Counting function: bit i toggles when habilita=1 and all lower bits are 0 (borrow = AND chain of ~q).
- Reset mid-operation: clr or prst asserted between edges takes effect immediately. Release is synchronous to the next edge with no spurious pulse.

Decomposition:
- Shared package constants: LARGURA=7, VALOR_MAX=7'd127, state encoding PARADO=1'b0, CONTANDO=1'b1.
- Natural sub-module: modulo_celula_descendente. It is one T flip-flop with clr/prst plus a 2-input AND forming borrow_out = borrow_in & ~q, and it is instantiated 7 times.
- Load is implemented per cell as t = (q xor valor_carga[i]) when carrega=1.
- The FSM and pulse registers live in the top module.

Test Plan:
- Reset: pulse clr mid-clock -> q=0, zero=1, fim=0, emprestimo=0 immediately. habilita=1 for 5 cycles -> q stays 0 (PARADO).
- Stop mode: modo_parada=1, load 3, habilita=1 -> q=2,1,0 on consecutive edges. fim=1 only in the cycle q=0. q stays 0 for 4 more cycles.
- Wrap mode: modo_parada=0, load 1, habilita=1 -> q=0 then 127 with emprestimo=1 for one cycle, then 126 with emprestimo=0.
- Priority: carrega=1, valor_carga=50, habilita=1 with q=10 -> q=50 (no decrement). habilita=0 for 3 cycles -> q holds 50.
- Preset/clear: prst with q=20 -> q=127 asynchronously. prst and clr together -> q=0. Release both, load 5, count -> 4,3.
- Mode change: in stop mode with q=0 in PARADO, set modo_parada=0 -> one edge without change, then q=127 with emprestimo=1.
